// File: rtl/bus_arbiter_rr_if.sv
// Shared master-bus signal bundle seen by the round-robin arbiter.
// The slave modport is the arbiter's view; the master modport is the
// view of the requesters and the bus (they drive requests and activity,
// and observe grants, aborts and ownership).
interface bus_arbiter_rr_if #(
  parameter int NR_MASTERS = 4
);
  logic [NR_MASTERS-1:0] request;
  logic [NR_MASTERS-1:0] grant;
  logic                  beginTransactionIn;
  logic                  endTransactionIn;
  logic                  dataValidIn;
  logic                  busyIn;
  logic                  busErrorOut;
  logic                  endTransactionOut;
  logic [2:0]            ownerId;
  logic                  busIdle;

  modport slave (
    input  request,
    input  beginTransactionIn,
    input  endTransactionIn,
    input  dataValidIn,
    input  busyIn,
    output grant,
    output busErrorOut,
    output endTransactionOut,
    output ownerId,
    output busIdle
  );

  modport master (
    output request,
    output beginTransactionIn,
    output endTransactionIn,
    output dataValidIn,
    output busyIn,
    input  grant,
    input  busErrorOut,
    input  endTransactionOut,
    input  ownerId,
    input  busIdle
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for the shared master bus with begin timeout and
// transaction watchdog.
//
// Handshake: request[i] is a level held by master i until it sees grant[i],
// a single-cycle registered pulse. The granted master then has
// BEGIN_TIMEOUT cycles to raise beginTransactionIn; the transaction lasts
// until endTransactionIn. If no dataValidIn/busyIn activity occurs for
// WATCHDOG cycles, the arbiter emits busErrorOut and endTransactionOut
// together for one cycle and returns to idle. All outputs are registered.
module bus_arbiter_rr #(
  parameter int NR_MASTERS    = 4,
  parameter int BEGIN_TIMEOUT = 16,
  parameter int WATCHDOG      = 1023
) (
  input  logic                clock,
  input  logic                reset,
  bus_arbiter_rr_if.slave     bus,
  output logic [2:0]          dbg_state
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_GRANT      = 3'd1;
  localparam logic [2:0] ST_WAIT_BEGIN = 3'd2;
  localparam logic [2:0] ST_BUSY       = 3'd3;
  localparam logic [2:0] ST_ABORT      = 3'd4;

  localparam logic [15:0] BEGIN_LIMIT = 16'(BEGIN_TIMEOUT);
  localparam logic [15:0] WDOG_LIMIT  = 16'(WATCHDOG);

  logic [2:0]            state_q, state_d;
  logic [15:0]           timer_q, timer_d;
  logic [2:0]            ptr_q, ptr_d;
  logic [2:0]            owner_q, owner_d;
  logic [NR_MASTERS-1:0] grant_q, grant_d;
  logic                  abort_q, abort_d;
  logic                  idle_q, idle_d;

  logic                  win_found;
  logic [2:0]            win_idx;
  int                    scan_idx;
  logic [15:0]           timer_inc;

  // Pick the first requester after the last winner, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    scan_idx  = 0;
    for (int i = 1; i <= NR_MASTERS; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= NR_MASTERS) scan_idx = scan_idx - NR_MASTERS;
      if (!win_found && bus.request[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = 3'(scan_idx);
      end
    end
  end

  // Saturating increment so the timer never wraps back to a small value.
  assign timer_inc = (timer_q == 16'hFFFF) ? timer_q : timer_q + 16'd1;

  // Next-state, timer, pointer and registered-output computation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = '0;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (win_found) begin
          state_d = ST_GRANT;
          ptr_d   = win_idx;
          owner_d = win_idx;
          grant_d = NR_MASTERS'(1) << win_idx;
        end
      end
      ST_GRANT: begin
        state_d = ST_WAIT_BEGIN;
        timer_d = '0;
      end
      ST_WAIT_BEGIN: begin
        if (bus.beginTransactionIn) begin
          state_d = ST_BUSY;
          timer_d = '0;
        end else if (timer_q == BEGIN_LIMIT) begin
          // Grant forfeited silently; ptr keeps the winner.
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_BUSY: begin
        if (bus.endTransactionIn) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == WDOG_LIMIT) begin
          state_d = ST_ABORT;
          timer_d = '0;
        end else if (bus.dataValidIn || bus.busyIn) begin
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_ABORT: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    abort_d = (state_d == ST_ABORT);
    idle_d  = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      abort_q <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      abort_q <= abort_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.grant             = grant_q;
  assign bus.busErrorOut       = abort_q;
  assign bus.endTransactionOut = abort_q;
  assign bus.ownerId           = owner_q;
  assign bus.busIdle           = idle_q;
  assign dbg_state             = state_q;

endmodule
